mem_access_stage: RTL and testbench

- MIPS MEM pipeline stage, directly upstream of the write-back mux.
- Takes EX/MEM results, performs data-memory load/store over a req/ack bus, and registers the MEM/WB fields the write-back stage consumes: read-enable, memory data, ALU result, destination and write enable.
- Stalls the upstream pipeline while a memory access is outstanding.

---
 rtl/mem_access_stage_pkg.sv | 24 ++
 rtl/mem_access_stage_wb_reg.sv | 42 ++++
 rtl/mem_access_stage.sv | 140 ++++++++++++++
 tb/tb_mem_access_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared widths, FSM encoding and side-band payload for the MEM pipeline stage.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

package mem_access_stage_pkg;

  localparam int unsigned DATA_W = `WORD_LEN;
  localparam int unsigned REG_AW = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Fields carried alongside a memory op until it retires into MEM/WB.
  typedef struct packed {
    logic              mem_rd_en;
    logic              wb_en;
    logic [REG_AW-1:0] dest_reg;
    logic [DATA_W-1:0] alu_result;
  } side_t;

endpackage

// File: rtl/mem_access_stage_wb_reg.sv
// MEM/WB output register bank: loads on retire, qualifies wb_en with the valid pulse.
module mem_wb_reg
  import mem_access_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              load_data,
  input  side_t             side,
  input  logic [DATA_W-1:0] rdata,
  output logic              valid,
  output logic              mem_rd_en,
  output logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] alu_result,
  output logic              wb_en,
  output logic [REG_AW-1:0] dest_reg
);

  // Payload fields hold between retires; valid and wb_en are single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid      <= 1'b0;
      wb_en      <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_data   <= '0;
      alu_result <= '0;
      dest_reg   <= '0;
    end else begin
      valid <= load;
      wb_en <= load & side.wb_en;
      if (load) begin
        mem_rd_en  <= side.mem_rd_en;
        alu_result <= side.alu_result;
        dest_reg   <= side.dest_reg;
        if (load_data) begin
          mem_data <= rdata;
        end
      end
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: data-memory req/ack handshake, upstream stall and MEM/WB registers.
// Optional alignment check (o_misalign port) enabled by defining MEM_ALIGN_CHK_EN.
module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic              i_mem_rd_en,
  input  logic              i_mem_wr_en,
  input  logic              i_wb_en,
  input  logic [REG_AW-1:0] i_dest_reg,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [DATA_W-1:0] i_store_data,
  output logic              o_stall,
  output logic              o_dm_req,
  output logic              o_dm_we,
  output logic [DATA_W-1:0] o_dm_addr,
  output logic [DATA_W-1:0] o_dm_wdata,
  input  logic              i_dm_ack,
  input  logic [DATA_W-1:0] i_dm_rdata,
  output logic              o_valid,
  output logic              o_mem_rd_en,
  output logic [DATA_W-1:0] o_mem_data,
  output logic [DATA_W-1:0] o_alu_result,
  output logic              o_wb_en,
  output logic [REG_AW-1:0] o_dest_reg
`ifdef MEM_ALIGN_CHK_EN
  ,
  output logic              o_misalign
`endif
);

  state_e state_q;
  state_e state_d;
  logic   is_mem;
  logic   misalign;
  logic   issue;
  logic   pass;
  logic   done;
  logic   wb_load;
  logic   wb_data_load;
  side_t  side_in;
  side_t  side_q;
  side_t  wb_side;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; no timeout while waiting for ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (issue)    state_d = ST_BUSY;
      ST_BUSY: if (i_dm_ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Decode: issue goes to memory, pass retires next cycle, done retires on ack.
  always_comb begin
    is_mem   = i_mem_rd_en | i_mem_wr_en;
    misalign = 1'b0;
`ifdef MEM_ALIGN_CHK_EN
    misalign = is_mem & (i_alu_result[1:0] != 2'b00);
`endif
    issue = 1'b0;
    pass  = 1'b0;
    done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        issue = i_valid & is_mem & ~misalign;
        pass  = i_valid & ~(is_mem & ~misalign);
      end
      ST_BUSY: done = i_dm_ack;
      default: ;
    endcase
    side_in.mem_rd_en  = i_mem_rd_en;
    side_in.wb_en      = i_wb_en & ~misalign;
    side_in.dest_reg   = i_dest_reg;
    side_in.alu_result = i_alu_result;
    wb_load      = pass | done;
    wb_data_load = done & side_q.mem_rd_en;
    wb_side      = done ? side_q : side_in;
  end

  assign o_stall = (state_q != ST_IDLE);

  // Data-memory request registers plus side-band latched at issue.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dm_req   <= 1'b0;
      o_dm_we    <= 1'b0;
      o_dm_addr  <= '0;
      o_dm_wdata <= '0;
      side_q     <= '0;
    end else if (issue) begin
      o_dm_req   <= 1'b1;
      o_dm_we    <= i_mem_wr_en & ~i_mem_rd_en;
      o_dm_addr  <= i_alu_result;
      o_dm_wdata <= i_store_data;
      side_q     <= side_in;
    end else if (done) begin
      o_dm_req <= 1'b0;
      o_dm_we  <= 1'b0;
    end
  end

`ifdef MEM_ALIGN_CHK_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_misalign <= 1'b0;
    end else begin
      o_misalign <= pass & misalign;
    end
  end
`endif

  mem_wb_reg u_mem_wb_reg (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .load       (wb_load),
    .load_data  (wb_data_load),
    .side       (wb_side),
    .rdata      (i_dm_rdata),
    .valid      (o_valid),
    .mem_rd_en  (o_mem_rd_en),
    .mem_data   (o_mem_data),
    .alu_result (o_alu_result),
    .wb_en      (o_wb_en),
    .dest_reg   (o_dest_reg)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (covers MEM_ALIGN_CHK_EN when defined).
module tb_mem_access_stage;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic        rd;
  logic        wr;
  logic        wb;
  logic [4:0]  dest;
  logic [31:0] alu;
  logic [31:0] sd;
  logic        ack;
  logic [31:0] rdata;

  logic        o_stall;
  logic        o_dm_req;
  logic        o_dm_we;
  logic [31:0] o_dm_addr;
  logic [31:0] o_dm_wdata;
  logic        o_valid;
  logic        o_mem_rd_en;
  logic [31:0] o_mem_data;
  logic [31:0] o_alu_result;
  logic        o_wb_en;
  logic [4:0]  o_dest_reg;
`ifdef MEM_ALIGN_CHK_EN
  logic        o_misalign;
`endif

  int n_vec;
  int n_err;

  mem_access_stage dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (valid),
    .i_mem_rd_en  (rd),
    .i_mem_wr_en  (wr),
    .i_wb_en      (wb),
    .i_dest_reg   (dest),
    .i_alu_result (alu),
    .i_store_data (sd),
    .o_stall      (o_stall),
    .o_dm_req     (o_dm_req),
    .o_dm_we      (o_dm_we),
    .o_dm_addr    (o_dm_addr),
    .o_dm_wdata   (o_dm_wdata),
    .i_dm_ack     (ack),
    .i_dm_rdata   (rdata),
    .o_valid      (o_valid),
    .o_mem_rd_en  (o_mem_rd_en),
    .o_mem_data   (o_mem_data),
    .o_alu_result (o_alu_result),
    .o_wb_en      (o_wb_en),
    .o_dest_reg   (o_dest_reg)
`ifdef MEM_ALIGN_CHK_EN
    ,
    .o_misalign   (o_misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b1; rd = 1'b0; wr = 1'b0; wb = 1'b1;
    dest = 5'd3; alu = 32'h55; sd = 32'h0; ack = 1'b0; rdata = 32'h0;
    tick(); tick();
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%h exp=0", o_valid); end
    n_vec++; if (o_dm_req !== 1'b0) begin n_err++; $display("FAIL rst_req got=%h exp=0", o_dm_req); end
    n_vec++; if (o_dm_we !== 1'b0) begin n_err++; $display("FAIL rst_we got=%h exp=0", o_dm_we); end
    n_vec++; if (o_dm_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr got=%h exp=0", o_dm_addr); end
    n_vec++; if (o_dm_wdata !== 32'h0) begin n_err++; $display("FAIL rst_wdata got=%h exp=0", o_dm_wdata); end
    n_vec++; if (o_mem_rd_en !== 1'b0) begin n_err++; $display("FAIL rst_rd_en got=%h exp=0", o_mem_rd_en); end
    n_vec++; if (o_mem_data !== 32'h0) begin n_err++; $display("FAIL rst_mem_data got=%h exp=0", o_mem_data); end
    n_vec++; if (o_alu_result !== 32'h0) begin n_err++; $display("FAIL rst_alu got=%h exp=0", o_alu_result); end
    n_vec++; if (o_wb_en !== 1'b0) begin n_err++; $display("FAIL rst_wb_en got=%h exp=0", o_wb_en); end
    n_vec++; if (o_dest_reg !== 5'd0) begin n_err++; $display("FAIL rst_dest got=%h exp=0", o_dest_reg); end
    n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got=%h exp=0", o_stall); end
`ifdef MEM_ALIGN_CHK_EN
    n_vec++; if (o_misalign !== 1'b0) begin n_err++; $display("FAIL rst_misalign got=%h exp=0", o_misalign); end
`endif
    rst_n = 1'b1;
    tick();
    valid = 1'b0;
    n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL first_valid got=%h exp=1", o_valid); end
    n_vec++; if (o_alu_result !== 32'h55) begin n_err++; $display("FAIL first_alu got=%h exp=55", o_alu_result); end
    n_vec++; if (o_dest_reg !== 5'd3) begin n_err++; $display("FAIL first_dest got=%h exp=3", o_dest_reg); end
    tick();
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL first_valid_drop got=%h exp=0", o_valid); end
    n_vec++; if (o_wb_en !== 1'b0) begin n_err++; $display("FAIL first_wb_drop got=%h exp=0", o_wb_en); end
    n_vec++; if (o_alu_result !== 32'h55) begin n_err++; $display("FAIL first_alu_hold got=%h exp=55", o_alu_result); end
  endtask

  task automatic test_alu_op();
    valid = 1'b1; rd = 1'b0; wr = 1'b0; wb = 1'b1; dest = 5'd7; alu = 32'h0000_00A5;
    tick();
    valid = 1'b0;
    n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL alu_valid got=%h exp=1", o_valid); end
    n_vec++; if (o_alu_result !== 32'hA5) begin n_err++; $display("FAIL alu_result got=%h exp=a5", o_alu_result); end
    n_vec++; if (o_mem_rd_en !== 1'b0) begin n_err++; $display("FAIL alu_rd_en got=%h exp=0", o_mem_rd_en); end
    n_vec++; if (o_wb_en !== 1'b1) begin n_err++; $display("FAIL alu_wb_en got=%h exp=1", o_wb_en); end
    n_vec++; if (o_dest_reg !== 5'd7) begin n_err++; $display("FAIL alu_dest got=%h exp=7", o_dest_reg); end
    n_vec++; if (o_dm_req !== 1'b0) begin n_err++; $display("FAIL alu_req got=%h exp=0", o_dm_req); end
    n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL alu_stall got=%h exp=0", o_stall); end
    tick();
  endtask

  task automatic test_load_delay();
    valid = 1'b1; rd = 1'b1; wr = 1'b0; wb = 1'b1; dest = 5'd9; alu = 32'h100;
    tick();
    valid = 1'b0; rd = 1'b0; alu = 32'hFFFF; dest = 5'd1;
    for (int c = 0; c < 3; c++) begin
      n_vec++; if (o_dm_req !== 1'b1) begin n_err++; $display("FAIL ld_req cyc%0d got=%h exp=1", c, o_dm_req); end
      n_vec++; if (o_stall !== 1'b1) begin n_err++; $display("FAIL ld_stall cyc%0d got=%h exp=1", c, o_stall); end
      n_vec++; if (o_dm_addr !== 32'h100) begin n_err++; $display("FAIL ld_addr cyc%0d got=%h exp=100", c, o_dm_addr); end
      n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL ld_early_valid cyc%0d got=%h exp=0", c, o_valid); end
      if (c == 2) begin ack = 1'b1; rdata = 32'hDEAD_BEEF; end
      tick();
    end
    ack = 1'b0; rdata = 32'h0;
    n_vec++; if (o_dm_req !== 1'b0) begin n_err++; $display("FAIL ld_req_drop got=%h exp=0", o_dm_req); end
    n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL ld_stall_drop got=%h exp=0", o_stall); end
    n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL ld_valid got=%h exp=1", o_valid); end
    n_vec++; if (o_mem_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ld_data got=%h exp=deadbeef", o_mem_data); end
    n_vec++; if (o_mem_rd_en !== 1'b1) begin n_err++; $display("FAIL ld_rd_en got=%h exp=1", o_mem_rd_en); end
    n_vec++; if (o_dest_reg !== 5'd9) begin n_err++; $display("FAIL ld_dest got=%h exp=9", o_dest_reg); end
    n_vec++; if (o_alu_result !== 32'h100) begin n_err++; $display("FAIL ld_alu got=%h exp=100", o_alu_result); end
    n_vec++; if (o_wb_en !== 1'b1) begin n_err++; $display("FAIL ld_wb_en got=%h exp=1", o_wb_en); end
    tick();
  endtask

  task automatic test_back_to_back();
    valid = 1'b1; rd = 1'b0; wr = 1'b1; wb = 1'b0; dest = 5'd0; alu = 32'h40; sd = 32'h1234;
    tick();
    valid = 1'b0; wr = 1'b0;
    n_vec++; if (o_dm_req !== 1'b1) begin n_err++; $display("FAIL st_req got=%h exp=1", o_dm_req); end
    n_vec++; if (o_dm_we !== 1'b1) begin n_err++; $display("FAIL st_we got=%h exp=1", o_dm_we); end
    n_vec++; if (o_dm_addr !== 32'h40) begin n_err++; $display("FAIL st_addr got=%h exp=40", o_dm_addr); end
    n_vec++; if (o_dm_wdata !== 32'h1234) begin n_err++; $display("FAIL st_wdata got=%h exp=1234", o_dm_wdata); end
    ack = 1'b1; rdata = 32'h5555_AAAA;
    tick();
    ack = 1'b0;
    valid = 1'b1; wb = 1'b1; dest = 5'd12; alu = 32'h3C;
    n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL st_valid got=%h exp=1", o_valid); end
    n_vec++; if (o_wb_en !== 1'b0) begin n_err++; $display("FAIL st_wb_en got=%h exp=0", o_wb_en); end
    n_vec++; if (o_mem_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL st_data_hold got=%h exp=deadbeef", o_mem_data); end
    n_vec++; if (o_mem_rd_en !== 1'b0) begin n_err++; $display("FAIL st_rd_en got=%h exp=0", o_mem_rd_en); end
    n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL st_stall got=%h exp=0", o_stall); end
    tick();
    valid = 1'b0;
    n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid got=%h exp=1", o_valid); end
    n_vec++; if (o_alu_result !== 32'h3C) begin n_err++; $display("FAIL b2b_alu got=%h exp=3c", o_alu_result); end
    n_vec++; if (o_dest_reg !== 5'd12) begin n_err++; $display("FAIL b2b_dest got=%h exp=c", o_dest_reg); end
    n_vec++; if (o_wb_en !== 1'b1) begin n_err++; $display("FAIL b2b_wb_en got=%h exp=1", o_wb_en); end
    n_vec++; if (o_dm_req !== 1'b0) begin n_err++; $display("FAIL b2b_req got=%h exp=0", o_dm_req); end
    tick();
  endtask

  task automatic test_rd_wr_both();
    valid = 1'b1; rd = 1'b1; wr = 1'b1; wb = 1'b1; dest = 5'd4; alu = 32'h80; sd = 32'h77;
    tick();
    valid = 1'b0; rd = 1'b0; wr = 1'b0;
    n_vec++; if (o_dm_req !== 1'b1) begin n_err++; $display("FAIL both_req got=%h exp=1", o_dm_req); end
    n_vec++; if (o_dm_we !== 1'b0) begin n_err++; $display("FAIL both_we got=%h exp=0", o_dm_we); end
    ack = 1'b1; rdata = 32'h0000_CAFE;
    tick();
    ack = 1'b0;
    n_vec++; if (o_mem_data !== 32'hCAFE) begin n_err++; $display("FAIL both_data got=%h exp=cafe", o_mem_data); end
    n_vec++; if (o_mem_rd_en !== 1'b1) begin n_err++; $display("FAIL both_rd_en got=%h exp=1", o_mem_rd_en); end
    tick();
  endtask

`ifdef MEM_ALIGN_CHK_EN
  task automatic test_misalign();
    valid = 1'b1; rd = 1'b1; wr = 1'b0; wb = 1'b1; dest = 5'd6; alu = 32'h102;
    tick();
    valid = 1'b0; rd = 1'b0;
    n_vec++; if (o_dm_req !== 1'b0) begin n_err++; $display("FAIL mis_req got=%h exp=0", o_dm_req); end
    n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL mis_stall got=%h exp=0", o_stall); end
    n_vec++; if (o_misalign !== 1'b1) begin n_err++; $display("FAIL mis_flag got=%h exp=1", o_misalign); end
    n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL mis_valid got=%h exp=1", o_valid); end
    n_vec++; if (o_wb_en !== 1'b0) begin n_err++; $display("FAIL mis_wb_en got=%h exp=0", o_wb_en); end
    tick();
    n_vec++; if (o_misalign !== 1'b0) begin n_err++; $display("FAIL mis_flag_drop got=%h exp=0", o_misalign); end
  endtask
`endif

  task automatic test_reset_busy();
    valid = 1'b1; rd = 1'b1; wr = 1'b0; wb = 1'b1; dest = 5'd5; alu = 32'h200;
    tick();
    valid = 1'b0; rd = 1'b0;
    n_vec++; if (o_dm_req !== 1'b1) begin n_err++; $display("FAIL rb_req got=%h exp=1", o_dm_req); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (o_dm_req !== 1'b0) begin n_err++; $display("FAIL rb_req_async got=%h exp=0", o_dm_req); end
    n_vec++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL rb_stall got=%h exp=0", o_stall); end
    rst_n = 1'b1;
    ack = 1'b1; rdata = 32'h1111_2222;
    tick();
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rb_late_ack_valid got=%h exp=0", o_valid); end
    tick();
    ack = 1'b0;
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rb_stray_ack_valid got=%h exp=0", o_valid); end
    n_vec++; if (o_mem_data !== 32'h0) begin n_err++; $display("FAIL rb_mem_data got=%h exp=0", o_mem_data); end
    n_vec++; if (o_dm_req !== 1'b0) begin n_err++; $display("FAIL rb_req_idle got=%h exp=0", o_dm_req); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_alu_op();
    test_load_delay();
    test_back_to_back();
    test_rd_wr_both();
`ifdef MEM_ALIGN_CHK_EN
    test_misalign();
`endif
    test_reset_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
